id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble/flush insertion.
- Sits directly downstream of the instruction decoder.
- Latches the decoded control word, operands and register numbers each cycle.
- Drives the stall signal back to the PC and the IF/ID register.

Parameters:
DW, 32, datapath width (operands, immediate, pc+4)
RW, 5, register-number width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
id_RegWrite  in  1  decoder control
id_MemToReg  in  1  decoder control (load)
id_MemWrite  in  1  decoder control
id_BranchEq  in  1  decoder control
id_Jump  in  1  decoder control
id_ALUSrc  in  1  decoder control
id_RegDst  in  1  1 = destination is rt, 0 = rd
id_LoadCtrl  in  1  decoder control (lh-type load)
id_ALUc  in  3  ALU operation
id_pc4  in  DW  pc+4 of the ID instruction
id_rs_data  in  DW  register-file read A
id_rt_data  in  DW  register-file read B
id_imm  in  DW  sign-extended immediate
id_rs  in  RW  rs field
id_rt  in  RW  rt field
id_rd  in  RW  rd field
flush  in  1  branch taken or jump resolved; kill the ID instruction
hold  in  1  global freeze (memory wait)
ex_* (same nine controls)  out  1/3  registered control word
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DW  registered data
ex_rs, ex_rt  out  RW  registered register numbers
ex_wreg  out  RW  resolved write register: id_RegDst ? id_rt : id_rd, registered
ex_valid  out  1  EX slot holds a real instruction
stall  out  1  combinational; 1 = PC and IF/ID must hold

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs, ex_wreg and ex_valid go to 0. stall reads 0 while in reset.
- Uses-rt: uses_rt = ~id_ALUSrc | id_MemWrite.
- Load-use hazard (combinational):
  - luh = ex_valid & ex_MemToReg & (ex_wreg != 0) & ((ex_wreg == id_rs) | (uses_rt & ex_wreg == id_rt)).
  - Register 0 never causes a hazard.
- Per rising clk, in priority order:
  1. hold=1: all registers keep their values; stall=1.
  2. flush=1: load a bubble (all controls 0, ex_valid=0; data fields don't-care, implemented as 0); stall=0. Flush overrides luh.
  3. luh=1: load a bubble; stall=1. The ID instruction is re-presented next cycle.
  4. Otherwise: capture all id_* values; ex_valid=1; stall=0.
- Load-use stall duration:
  - Exactly 1 cycle per load, because the bubble clears ex_valid and luh drops.
  - Back-to-back dependent loads each stall 1 cycle.
- Latency: 1 cycle from id_* to ex_*.
- No combinational path from id_* data to ex_*.
- Effective state machine, based on the previous cycle's action:
  - RUN → BUBBLE on luh or flush.
  - BUBBLE → RUN otherwise.
  - hold keeps the current state.
- stall is combinational from hold, flush and luh only. It does not depend on id data fields beyond rs/rt/ALUSrc/MemWrite.

Optional Feature:
ID_EX_PERF_CNT_EN:
- Defined:
  - Adds outputs perf_stall_cnt (32) and perf_flush_cnt (32), reset to 0.
  - perf_stall_cnt increments on each clock where luh & ~flush & ~hold.
  - perf_flush_cnt increments on each clock where flush & ~hold.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset → release rst_n, no flush/hold, present add (RegWrite=1, RegDst=0, rd=3) → one cycle later ex_valid=1, ex_wreg=3, ex_RegWrite=1, stall=0.
- Load-use → load (MemToReg=1, RegDst=1, rt=8) followed by add with rs=8 → stall=1 for exactly 1 cycle, then a bubble with ex_valid=0, then the add is captured next cycle.
- Register 0 / unused rt → load to rt=0 followed by a user of r0: no stall. Load to r9 followed by addi (ALUSrc=1) with rt=9: no stall. Load to r9 followed by sw with rt=9: stall.
- Flush priority → flush=1 in the same cycle luh=1 → stall=0; next cycle ex_valid=0 and all ex controls 0.
- Hold → hold=1 for 3 cycles with changing id_* inputs → ex_* unchanged and stall=1 throughout; on release, the current id_* is captured.
- Async reset mid-stream → drop rst_n between clock edges while ex_valid=1 → outputs are 0 immediately, without waiting for clk.
- With ID_EX_PERF_CNT_EN defined → 2 load-use events and 1 flush give perf_stall_cnt=2, perf_flush_cnt=1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if : signal bundle between the decoder side and the ID/EX stage.
//   master : decoder / hazard-resolution side (drives id_*, flush, hold;
//            observes ex_*, stall and, when ID_EX_PERF_CNT_EN is defined,
//            the perf counters)
//   slave  : the id_ex_stage pipeline register itself
// Parameters: DW datapath width, RW register-number width.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_RegWrite, id_MemToReg, id_MemWrite, id_BranchEq;
  logic          id_Jump, id_ALUSrc, id_RegDst, id_LoadCtrl;
  logic [2:0]    id_ALUc;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          flush, hold;

  logic          ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_BranchEq;
  logic          ex_Jump, ex_ALUSrc, ex_RegDst, ex_LoadCtrl;
  logic [2:0]    ex_ALUc;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_wreg;
  logic          ex_valid;
  logic          stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

  modport master (
    output id_RegWrite, id_MemToReg, id_MemWrite, id_BranchEq, id_Jump,
           id_ALUSrc, id_RegDst, id_LoadCtrl, id_ALUc, id_pc4, id_rs_data,
           id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
    input  ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_BranchEq, ex_Jump,
           ex_ALUSrc, ex_RegDst, ex_LoadCtrl, ex_ALUc, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, ex_valid, stall
`ifdef ID_EX_PERF_CNT_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_RegWrite, id_MemToReg, id_MemWrite, id_BranchEq, id_Jump,
           id_ALUSrc, id_RegDst, id_LoadCtrl, id_ALUc, id_pc4, id_rs_data,
           id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
    output ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_BranchEq, ex_Jump,
           ex_ALUSrc, ex_RegDst, ex_LoadCtrl, ex_ALUc, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, ex_valid, stall
`ifdef ID_EX_PERF_CNT_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage : ID/EX pipeline register with load-use hazard detection and
// bubble/flush insertion.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    id_ex_stage_if.slave: id_* decoded word in, flush/hold controls in,
//          registered ex_* word out, ex_valid out, combinational stall out
// Optional feature macro: ID_EX_PERF_CNT_EN adds perf_stall_cnt and
// perf_flush_cnt (32-bit wrapping event counters) to the bus.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_RUN    | last non-held edge captured the ID instruction
// S_BUBBLE | last non-held edge loaded a bubble (flush or load-use)
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  typedef enum logic {S_RUN = 1'b0, S_BUBBLE = 1'b1} state_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          branch_eq;
    logic          jump;
    logic          alu_src;
    logic          reg_dst;
    logic          load_ctrl;
    logic [2:0]    alu_c;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wreg;
    logic          valid;
  } ex_word_t;

  state_t   state_q, state_d;
  ex_word_t ex_q, id_word;
  logic     uses_rt, luh, load_bubble, stall_raw;

  always_comb begin
    id_word            = '0;
    id_word.reg_write  = bus.id_RegWrite;
    id_word.mem_to_reg = bus.id_MemToReg;
    id_word.mem_write  = bus.id_MemWrite;
    id_word.branch_eq  = bus.id_BranchEq;
    id_word.jump       = bus.id_Jump;
    id_word.alu_src    = bus.id_ALUSrc;
    id_word.reg_dst    = bus.id_RegDst;
    id_word.load_ctrl  = bus.id_LoadCtrl;
    id_word.alu_c      = bus.id_ALUc;
    id_word.pc4        = bus.id_pc4;
    id_word.rs_data    = bus.id_rs_data;
    id_word.rt_data    = bus.id_rt_data;
    id_word.imm        = bus.id_imm;
    id_word.rs         = bus.id_rs;
    id_word.rt         = bus.id_rt;
    id_word.wreg       = bus.id_RegDst ? bus.id_rt : bus.id_rd;
    id_word.valid      = 1'b1;
  end

  // Only rs/rt/ALUSrc/MemWrite of the ID word reach the hazard compare.
  assign uses_rt = ~bus.id_ALUSrc | bus.id_MemWrite;
  assign luh = ex_q.valid & ex_q.mem_to_reg & (ex_q.wreg != '0) &
               ((ex_q.wreg == bus.id_rs) | (uses_rt & (ex_q.wreg == bus.id_rt)));

  always_comb begin
    state_d     = state_q;
    load_bubble = 1'b0;
    stall_raw   = 1'b0;
    if (bus.hold) begin
      stall_raw = 1'b1;
    end else if (bus.flush) begin
      load_bubble = 1'b1;
      state_d     = S_BUBBLE;
    end else if (luh) begin
      load_bubble = 1'b1;
      stall_raw   = 1'b1;
      state_d     = S_BUBBLE;
    end else begin
      state_d = S_RUN;
    end
  end

  // A held reset must not freeze the front end.
  assign bus.stall = stall_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ex_q    <= '0;
    end else if (!bus.hold) begin
      state_q <= state_d;
      ex_q    <= load_bubble ? '0 : id_word;
    end
  end

  assign bus.ex_RegWrite = ex_q.reg_write;
  assign bus.ex_MemToReg = ex_q.mem_to_reg;
  assign bus.ex_MemWrite = ex_q.mem_write;
  assign bus.ex_BranchEq = ex_q.branch_eq;
  assign bus.ex_Jump     = ex_q.jump;
  assign bus.ex_ALUSrc   = ex_q.alu_src;
  assign bus.ex_RegDst   = ex_q.reg_dst;
  assign bus.ex_LoadCtrl = ex_q.load_ctrl;
  assign bus.ex_ALUc     = ex_q.alu_c;
  assign bus.ex_pc4      = ex_q.pc4;
  assign bus.ex_rs_data  = ex_q.rs_data;
  assign bus.ex_rt_data  = ex_q.rt_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_wreg     = ex_q.wreg;
  assign bus.ex_valid    = ex_q.valid;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Flush wins over luh, so a flushed hazard is not counted as a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (!bus.hold) begin
      if (bus.flush) perf_flush_q <= perf_flush_q + 32'd1;
      else if (luh)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage : directed test-plan sequences followed by randomized traffic,
// all checked against an instruction-level model of the ID/EX slot.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();
  id_ex_stage #(.DW(DW), .RW(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          reg_write, load, mem_write, branch_eq, jump, alu_src, rt_dest, load_h;
    bit [2:0]    alu_op;
    bit [DW-1:0] pc4, a, b, imm;
    bit [RW-1:0] rs, rt, rd;
  } instr_t;

  typedef struct {
    bit     valid;
    instr_t ins;
  } slot_t;

  int     checks = 0;
  int     failures = 0;
  instr_t cur;
  slot_t  m;
  bit [31:0] m_stall_cnt, m_flush_cnt;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0;
    s.ins   = nop();
    return s;
  endfunction

  function automatic bit [RW-1:0] dest_of(instr_t i);
    return i.rt_dest ? i.rt : i.rd;
  endfunction

  // A load in EX blocks any consumer that reads its (nonzero) destination.
  function automatic bit hazard(slot_t ex, instr_t id);
    bit [RW-1:0] dst;
    bit reads_rt;
    if (!ex.valid || !ex.ins.load) return 1'b0;
    dst = dest_of(ex.ins);
    if (dst == '0) return 1'b0;
    reads_rt = !id.alu_src || id.mem_write;
    return (dst == id.rs) || (reads_rt && dst == id.rt);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.reg_write = 1'($urandom);
    i.load      = ($urandom_range(0, 1) == 0);
    i.mem_write = 1'($urandom);
    i.branch_eq = 1'($urandom);
    i.jump      = 1'($urandom);
    i.alu_src   = 1'($urandom);
    i.rt_dest   = 1'($urandom);
    i.load_h    = 1'($urandom);
    i.alu_op    = 3'($urandom);
    i.pc4       = $urandom;
    i.a         = $urandom;
    i.b         = $urandom;
    i.imm       = $urandom;
    i.rs        = RW'($urandom_range(0, 3));
    i.rt        = RW'($urandom_range(0, 3));
    i.rd        = RW'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic drive(input instr_t i);
    cur = i;
    bus.id_RegWrite = i.reg_write;
    bus.id_MemToReg = i.load;
    bus.id_MemWrite = i.mem_write;
    bus.id_BranchEq = i.branch_eq;
    bus.id_Jump     = i.jump;
    bus.id_ALUSrc   = i.alu_src;
    bus.id_RegDst   = i.rt_dest;
    bus.id_LoadCtrl = i.load_h;
    bus.id_ALUc     = i.alu_op;
    bus.id_pc4      = i.pc4;
    bus.id_rs_data  = i.a;
    bus.id_rt_data  = i.b;
    bus.id_imm      = i.imm;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_rd       = i.rd;
  endtask

  task automatic check_ex(input string tag);
    instr_t e;
    e = m.ins;
    chk({tag, "_valid"}, 256'(bus.ex_valid), 256'(m.valid));
    chk({tag, "_ctrl"},
        256'({bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_MemWrite, bus.ex_BranchEq, bus.ex_Jump,
              bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_LoadCtrl, bus.ex_ALUc}),
        256'({e.reg_write, e.load, e.mem_write, e.branch_eq, e.jump,
              e.alu_src, e.rt_dest, e.load_h, e.alu_op}));
    chk({tag, "_data"}, 256'({bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm}),
        256'({e.pc4, e.a, e.b, e.imm}));
    chk({tag, "_regs"}, 256'({bus.ex_rs, bus.ex_rt, bus.ex_wreg}),
        256'({e.rs, e.rt, dest_of(e)}));
  endtask

  // One clock: apply flush/hold, check stall, advance model, check EX slot.
  task automatic cycle(input string tag, input bit f, input bit h);
    bit hz;
    bus.flush = f;
    bus.hold  = h;
    #1;
    hz = hazard(m, cur);
    chk({tag, "_stall"}, 256'(bus.stall), 256'(h || (!f && hz)));
    @(posedge clk);
    if (!h) begin
      if (f) m_flush_cnt++;
      else if (hz) m_stall_cnt++;
      if (f || hz) m = empty_slot();
      else begin
        m.valid = 1'b1;
        m.ins   = cur;
      end
    end
    #1;
    check_ex(tag);
  endtask

  initial begin
    instr_t add3, ld8, add8, ld0, use0, ld9, addi9, sw9;
    rst_n = 1'b0;
    drive(nop());
    bus.flush = 1'b0;
    bus.hold  = 1'b1;
    m = empty_slot();
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    repeat (2) @(negedge clk);
    check_ex("reset");
    chk("reset_stall", 256'(bus.stall), 256'(0));
    bus.hold = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    add3 = nop(); add3.reg_write = 1; add3.rd = 5'd3; add3.rs = 5'd1; add3.rt = 5'd2;
    add3.pc4 = 32'h104; add3.a = 32'h11; add3.b = 32'h22;
    drive(add3);
    cycle("add", 0, 0);
    chk("add_wreg", 256'(bus.ex_wreg), 256'(3));
    chk("add_valid1", 256'(bus.ex_valid), 256'(1));

    ld8 = nop(); ld8.reg_write = 1; ld8.load = 1; ld8.rt_dest = 1; ld8.alu_src = 1;
    ld8.rt = 5'd8; ld8.rs = 5'd4;
    add8 = nop(); add8.reg_write = 1; add8.rs = 5'd8; add8.rt = 5'd6; add8.rd = 5'd7;
    drive(ld8);  cycle("ld8", 0, 0);
    drive(add8); cycle("lu_stall", 0, 0);
    chk("lu_bubble", 256'(bus.ex_valid), 256'(0));
    cycle("lu_capture", 0, 0);
    chk("lu_capture_wreg", 256'(bus.ex_wreg), 256'(7));

    ld0 = ld8; ld0.rt = 5'd0;
    use0 = add8; use0.rs = 5'd0; use0.rt = 5'd0;
    drive(ld0);  cycle("ld0", 0, 0);
    drive(use0); cycle("r0_nostall", 0, 0);

    ld9 = ld8; ld9.rt = 5'd9;
    addi9 = nop(); addi9.alu_src = 1; addi9.rt = 5'd9; addi9.rt_dest = 1; addi9.rs = 5'd1;
    sw9 = nop(); sw9.alu_src = 1; sw9.mem_write = 1; sw9.rt = 5'd9; sw9.rs = 5'd1;
    drive(ld9);   cycle("ld9a", 0, 0);
    drive(addi9); cycle("addi_nostall", 0, 0);
    drive(ld9);   cycle("ld9b", 0, 0);
    drive(sw9);   cycle("sw_stall", 0, 0);
    cycle("sw_capture", 0, 0);

    drive(ld8);  cycle("ld8f", 0, 0);
    drive(add8); cycle("flush_prio", 1, 0);
    chk("flush_ctrl", 256'({bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_valid}), 256'(0));

    drive(add3); cycle("pre_hold", 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(rand_instr());
      cycle("hold", 0, 1);
    end
    drive(add8); cycle("hold_release", 0, 0);

    // Asynchronous reset between edges while the slot is valid.
    #2;
    rst_n = 1'b0;
    #1;
    m = empty_slot();
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    check_ex("async_rst");
    chk("async_rst_stall", 256'(bus.stall), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(ld8);  cycle("p_ld1", 0, 0);
    drive(add8); cycle("p_use1", 0, 0);
    cycle("p_cap1", 0, 0);
    drive(ld8);  cycle("p_ld2", 0, 0);
    drive(add8); cycle("p_use2", 0, 0);
    cycle("p_cap2", 0, 0);
    drive(add3); cycle("p_flush", 1, 0);
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_dir", 256'(bus.perf_stall_cnt), 256'(2));
    chk("perf_flush_dir", 256'(bus.perf_flush_cnt), 256'(1));
`endif

    for (int n = 0; n < 400; n++) begin
      drive(rand_instr());
      cycle("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_rand", 256'(bus.perf_stall_cnt), 256'(m_stall_cnt));
    chk("perf_flush_rand", 256'(bus.perf_flush_cnt), 256'(m_flush_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
